// File: rtl/mem_addr_gen.sv
// Burst address generator: loads a base address, then steps it by STRIDE per accepted beat.
// Optional address window wrap when MAR_WRAP_EN is defined (adds win_base / win_limit inputs).
//
//   state | meaning
//   IDLE  | waiting for load / burst request
//   BURST | presenting beats, advancing on mem_ready
//   DONE  | one-cycle completion pulse, then back to IDLE
module mem_addr_gen #(
    parameter int AW     = 16,
    parameter int CW     = 4,
    parameter int STRIDE = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] bus_in,
    input  logic          load_en,
    input  logic          burst_start,
    input  logic [CW-1:0] burst_len,
    input  logic          mem_ready,
`ifdef MAR_WRAP_EN
    input  logic [AW-1:0] win_base,
    input  logic [AW-1:0] win_limit,
`endif
    output logic [AW-1:0] addr_out,
    output logic          addr_valid,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [AW:0] LP_STRIDE = (AW+1)'(STRIDE);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_addr;
    logic [AW-1:0] w_addr_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_valid;
    logic          r_busy;
    logic          r_done;
    logic [AW:0]   w_sum;
    logic [AW-1:0] w_step_addr;

    // One extra bit so the window compare sees a carry past 2^AW-1.
    assign w_sum = {1'b0, r_addr} + LP_STRIDE;

`ifdef MAR_WRAP_EN
    assign w_step_addr = (w_sum > {1'b0, win_limit}) ? win_base : w_sum[AW-1:0];
`else
    assign w_step_addr = w_sum[AW-1:0];
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (load_en) begin
                    w_addr_nxt = bus_in;
                end
                if (burst_start && (burst_len != '0)) begin
                    w_state_nxt = BURST;
                    w_cnt_nxt   = burst_len;
                end
            end
            BURST: begin
                if (mem_ready) begin
                    w_addr_nxt = w_step_addr;
                    w_cnt_nxt  = r_cnt - 1'b1;
                    if (r_cnt == CW'(1)) begin
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_valid <= (w_state_nxt == BURST);
            r_busy  <= (w_state_nxt == BURST);
            r_done  <= (w_state_nxt == DONE);
        end
    end

    assign addr_out   = r_addr;
    assign addr_valid = r_valid;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule
